// File: rtl/verify_ram.sv
// verify_ram: AXI4 read-only memory checker. Reads BLOCKS bursts of BLOCK_SIZE bytes
// from BASE_ADDR and counts beats that differ from a constant fill byte, carry a
// non-OKAY response or have RLAST in the wrong place.
// Optional feature macro: VERIFY_RAM_FIRST_ERR_EN adds first_err_addr.
module verify_ram #(
    parameter int unsigned DW         = 512,
    parameter logic [7:0]  FILL_VALUE = 8'hFC,
    parameter logic [63:0] BASE_ADDR  = 64'h10_0000_0000,
    parameter int unsigned BLOCK_SIZE = 4096,
    parameter int unsigned BLOCKS     = 1024
) (
    input  logic            ram_clk,
    input  logic            ram_reset,
    input  logic            start,
    output logic            idle,
    output logic            pass,
    output logic [31:0]     error_count,
    output logic [63:0]     elapsed,
`ifdef VERIFY_RAM_FIRST_ERR_EN
    output logic [63:0]     first_err_addr,
`endif
    // read address channel
    output logic [63:0]     M_AXI_ARADDR,
    output logic [7:0]      M_AXI_ARLEN,
    output logic [2:0]      M_AXI_ARSIZE,
    output logic [1:0]      M_AXI_ARBURST,
    output logic [3:0]      M_AXI_ARID,
    output logic            M_AXI_ARLOCK,
    output logic [3:0]      M_AXI_ARCACHE,
    output logic [3:0]      M_AXI_ARQOS,
    output logic [2:0]      M_AXI_ARPROT,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    // read data channel
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RLAST,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY,
    // unused write channels, tied off
    output logic [63:0]     M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic [3:0]      M_AXI_AWID,
    output logic            M_AXI_AWVALID,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    output logic            M_AXI_BREADY
);

    localparam int unsigned BEAT_BYTES = DW / 8;
    localparam int unsigned BEATS      = BLOCK_SIZE / BEAT_BYTES;
    localparam int unsigned SIZE_LOG2  = $clog2(BEAT_BYTES);

    typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_e;
    typedef enum logic {R_IDLE, R_CHECK} r_state_e;

    ar_state_e   ar_state_q, ar_state_d;
    logic [63:0] araddr_q, araddr_d;
    logic [31:0] ar_count_q, ar_count_d;

    r_state_e    r_state_q, r_state_d;
    logic [8:0]  beat_q, beat_d;
    logic [31:0] block_q, block_d;
    logic [31:0] err_q, err_d;
    logic [63:0] elapsed_q, elapsed_d;
    logic        pass_q, pass_d;
`ifdef VERIFY_RAM_FIRST_ERR_EN
    logic [63:0] fe_q, fe_d;
    logic [63:0] beat_addr_q, beat_addr_d;
`endif

    logic last_beat;
    logic beat_err;

    // constant channel attributes and tie-offs
    assign M_AXI_ARLEN   = 8'(BEATS - 1);
    assign M_AXI_ARSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_RREADY  = 1'b1;
    assign M_AXI_AWADDR  = '0;
    assign M_AXI_AWLEN   = '0;
    assign M_AXI_AWSIZE  = '0;
    assign M_AXI_AWBURST = '0;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WDATA   = '0;
    assign M_AXI_WSTRB   = '0;
    assign M_AXI_WLAST   = 1'b0;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b1;

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = (ar_state_q == AR_ISSUE);

    assign idle        = (r_state_q == R_IDLE);
    assign pass        = pass_q;
    assign error_count = err_q;
    assign elapsed     = elapsed_q;
`ifdef VERIFY_RAM_FIRST_ERR_EN
    assign first_err_addr = fe_q;
`endif

    // Beat position comes from our own counter; RLAST is only checked, never trusted.
    assign last_beat = (beat_q == 9'(BEATS));
    assign beat_err  = (M_AXI_RDATA != {BEAT_BYTES{FILL_VALUE}}) ||
                       (M_AXI_RRESP != 2'b00) ||
                       (M_AXI_RLAST != last_beat);

    // AR FSM next state: issue BLOCKS back-to-back bursts, address held while stalled
    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        ar_count_d = ar_count_q;
        case (ar_state_q)
            AR_IDLE: begin
                if (start && idle) begin
                    ar_state_d = AR_ISSUE;
                    araddr_d   = BASE_ADDR;
                    ar_count_d = 32'd1;
                end
            end
            AR_ISSUE: begin
                if (M_AXI_ARREADY) begin
                    if (ar_count_q == BLOCKS) begin
                        ar_state_d = AR_IDLE;
                    end else begin
                        araddr_d   = araddr_q + 64'(BLOCK_SIZE);
                        ar_count_d = ar_count_q + 32'd1;
                    end
                end
            end
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // R FSM next state: check beats, count errors, time the pass
    always_comb begin
        r_state_d = r_state_q;
        beat_d    = beat_q;
        block_d   = block_q;
        err_d     = err_q;
        elapsed_d = elapsed_q;
        pass_d    = pass_q;
`ifdef VERIFY_RAM_FIRST_ERR_EN
        fe_d        = fe_q;
        beat_addr_d = beat_addr_q;
`endif
        case (r_state_q)
            R_IDLE: begin
                // beats arriving here are leftovers from an aborted pass: dropped
                if (start) begin
                    r_state_d = R_CHECK;
                    beat_d    = 9'd1;
                    block_d   = 32'd1;
                    err_d     = '0;
                    elapsed_d = '0;
`ifdef VERIFY_RAM_FIRST_ERR_EN
                    fe_d        = '1;
                    beat_addr_d = BASE_ADDR;
`endif
                end
            end
            R_CHECK: begin
                elapsed_d = elapsed_q + 64'd1;
                if (M_AXI_RVALID) begin
                    if (beat_err) begin
                        err_d = (err_q == '1) ? err_q : err_q + 32'd1;
`ifdef VERIFY_RAM_FIRST_ERR_EN
                        if (err_q == '0) fe_d = beat_addr_q;
`endif
                    end
`ifdef VERIFY_RAM_FIRST_ERR_EN
                    beat_addr_d = beat_addr_q + 64'(BEAT_BYTES);
`endif
                    if (last_beat) begin
                        beat_d = 9'd1;
                        if (block_q == BLOCKS) begin
                            r_state_d = R_IDLE;
                            pass_d    = (err_d == '0);
                        end else begin
                            block_d = block_q + 32'd1;
                        end
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge ram_clk) begin
        if (ram_reset) begin
            ar_state_q  <= AR_IDLE;
            araddr_q    <= BASE_ADDR;
            ar_count_q  <= '0;
            r_state_q   <= R_IDLE;
            beat_q      <= 9'd1;
            block_q     <= 32'd1;
            err_q       <= '0;
            elapsed_q   <= '0;
            pass_q      <= 1'b0;
`ifdef VERIFY_RAM_FIRST_ERR_EN
            fe_q        <= '1;
            beat_addr_q <= BASE_ADDR;
`endif
        end else begin
            ar_state_q  <= ar_state_d;
            araddr_q    <= araddr_d;
            ar_count_q  <= ar_count_d;
            r_state_q   <= r_state_d;
            beat_q      <= beat_d;
            block_q     <= block_d;
            err_q       <= err_d;
            elapsed_q   <= elapsed_d;
            pass_q      <= pass_d;
`ifdef VERIFY_RAM_FIRST_ERR_EN
            fe_q        <= fe_d;
            beat_addr_q <= beat_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_verify_ram.sv
// tb_verify_ram: directed, table-driven bench for verify_ram with a small AXI read slave
// that returns 0xFC-filled beats plus selectable data/response/RLAST faults and AR stalls.
module tb_verify_ram;

    localparam int unsigned DW    = 512;
    localparam int unsigned BS    = 256;
    localparam int unsigned NBLK  = 4;
    localparam int          BEATS = 4;
    localparam logic [63:0] BASE  = 64'h10_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ram_reset = 1'b1;
    logic start = 1'b0;
    logic idle, pass;
    logic [31:0] error_count;
    logic [63:0] elapsed;
`ifdef VERIFY_RAM_FIRST_ERR_EN
    logic [63:0] first_err_addr;
`endif
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid, arcache, arqos;
    logic        arlock, arvalid;
    logic [2:0]  arprot;
    logic        ar_ready = 1'b1;
    logic [DW-1:0] r_data = '0;
    logic [1:0]  r_resp = 2'b00;
    logic        r_last = 1'b0;
    logic        r_valid = 1'b0;
    logic        rready;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        awvalid, wlast, wvalid, bready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;

    verify_ram #(
        .DW(DW), .FILL_VALUE(8'hFC), .BASE_ADDR(BASE), .BLOCK_SIZE(BS), .BLOCKS(NBLK)
    ) dut (
        .ram_clk(clk), .ram_reset(ram_reset), .start(start),
        .idle(idle), .pass(pass), .error_count(error_count), .elapsed(elapsed),
`ifdef VERIFY_RAM_FIRST_ERR_EN
        .first_err_addr(first_err_addr),
`endif
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARID(arid), .M_AXI_ARLOCK(arlock),
        .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos), .M_AXI_ARPROT(arprot),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(ar_ready),
        .M_AXI_RDATA(r_data), .M_AXI_RRESP(r_resp), .M_AXI_RLAST(r_last),
        .M_AXI_RVALID(r_valid), .M_AXI_RREADY(rready),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWID(awid), .M_AXI_AWVALID(awvalid),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_BREADY(bready)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // slave state and fault injection knobs
    logic [63:0] burst_q[$];
    logic [63:0] ar_log[$];
    int beat_idx = 1;
    int ar_seen = 0;
    int ar_attr_bad = 0;
    int r_beats = 0;
    int stall_idx = 0, stall_left = 0, stall_cycles = 0, stall_bad = 0;
    logic [63:0] stall_addr = '0;
    int cor_blk = 0, cor_beat = 0, resp_blk = 0, resp_beat = 0, nolast_blk = 0;

    // AXI read slave: decide handshakes at negedge, update drives 1 time unit after posedge
    initial begin : slave
        logic ar_hs, r_hs;
        logic [63:0] a_addr;
        logic [DW-1:0] d;
        int blk;
        forever begin
            @(negedge clk);
            if (stall_left > 0 && ar_seen + 1 == stall_idx && (arvalid || stall_cycles > 0)) begin
                ar_ready = 1'b0;
                stall_cycles++;
                stall_left--;
                if (!arvalid || araddr != stall_addr) stall_bad++;
            end else begin
                ar_ready = 1'b1;
            end
            ar_hs  = arvalid && ar_ready;
            a_addr = araddr;
            if (ar_hs && (arlen != 8'd3 || arsize != 3'd6 || arburst != 2'd1 || arid != 4'd0))
                ar_attr_bad++;
            r_hs = r_valid && rready;
            @(posedge clk);
            #1;
            if (ar_hs) begin
                burst_q.push_back(a_addr);
                ar_log.push_back(a_addr);
                ar_seen++;
            end
            if (r_hs) begin
                r_beats++;
                beat_idx++;
                if (beat_idx > BEATS) begin
                    void'(burst_q.pop_front());
                    beat_idx = 1;
                end
            end
            if (burst_q.size() > 0) begin
                blk = int'((burst_q[0] - BASE) / 64'(BS)) + 1;
                d = {64{8'hFC}};
                if (blk == cor_blk && beat_idx == cor_beat) d[40 +: 8] = 8'h00;
                r_data  = d;
                r_resp  = (blk == resp_blk && beat_idx == resp_beat) ? 2'b10 : 2'b00;
                r_last  = (beat_idx == BEATS) && (blk != nolast_blk);
                r_valid = 1'b1;
            end else begin
                r_valid = 1'b0;
                r_last  = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_slave();
        ar_log.delete();
        ar_seen = 0;
        ar_attr_bad = 0;
        r_beats = 0;
        stall_cycles = 0;
        stall_bad = 0;
    endtask

    // Pulse start, optionally pulse it again mid-pass, count cycles until idle returns
    task automatic run_pass(input bit mid, output int cyc, output bit to);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (idle) begin
                to = 1'b0;
                break;
            end
            cyc++;
            start = (mid && cyc == 8);
        end
        start = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          cor_blk, cor_beat, resp_blk, resp_beat, nolast_blk;
        int          stall_idx, stall_n;
        bit          mid;
        int          exp_err;
        bit          exp_pass;
        logic [63:0] exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        int cyc, base_cyc;
        bit to;
        vec_t v;

        vecs[0] = '{"clean",     0, 0, 0, 0, 0, 0, 0,  1'b0, 0, 1'b1, ONES};
        vecs[1] = '{"data_err",  3, 2, 0, 0, 0, 0, 0,  1'b0, 1, 1'b0, BASE + 64'd576};
        vecs[2] = '{"ar_stall",  0, 0, 0, 0, 0, 2, 10, 1'b0, 0, 1'b1, ONES};
        vecs[3] = '{"rresp_err", 0, 0, 2, 3, 0, 0, 0,  1'b0, 1, 1'b0, BASE + 64'd384};
        vecs[4] = '{"no_rlast",  0, 0, 0, 0, 1, 0, 0,  1'b0, 1, 1'b0, BASE + 64'd192};
        vecs[5] = '{"two_errs",  1, 1, 4, 4, 0, 0, 0,  1'b0, 2, 1'b0, BASE};
        vecs[6] = '{"mid_start", 0, 0, 0, 0, 0, 0, 0,  1'b1, 0, 1'b1, ONES};
        base_cyc = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1 ram_reset = 1'b0;
        @(negedge clk);
        check("rst idle", 64'(idle), 64'd1);
        check("rst pass", 64'(pass), 64'd0);
        check("rst err", 64'(error_count), 64'd0);
        check("rst elapsed", elapsed, 64'd0);
        check("rst arvalid", 64'(arvalid), 64'd0);
        check("rready", 64'(rready), 64'd1);
        check("bready", 64'(bready), 64'd1);
        check("awvalid", 64'(awvalid), 64'd0);
        check("wvalid", 64'(wvalid), 64'd0);
`ifdef VERIFY_RAM_FIRST_ERR_EN
        check("rst first_err", first_err_addr, ONES);
`endif

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            clear_slave();
            cor_blk = v.cor_blk;     cor_beat = v.cor_beat;
            resp_blk = v.resp_blk;   resp_beat = v.resp_beat;
            nolast_blk = v.nolast_blk;
            stall_idx = v.stall_idx; stall_left = v.stall_n;
            stall_addr = BASE + 64'd256;
            run_pass(v.mid, cyc, to);
            check({v.name, " timeout"}, 64'(to), 64'd0);
            check({v.name, " err"}, 64'(error_count), 64'(v.exp_err));
            check({v.name, " pass"}, 64'(pass), 64'(v.exp_pass));
            check({v.name, " elapsed"}, elapsed, 64'(cyc));
            check({v.name, " ar count"}, 64'(ar_seen), 64'(NBLK));
            check({v.name, " ar attrs"}, 64'(ar_attr_bad), 64'd0);
            for (int k = 0; k < int'(NBLK); k++)
                check({v.name, " araddr"}, (k < ar_log.size()) ? ar_log[k] : ONES,
                      BASE + 64'(k * BS));
            if (v.stall_n > 0) begin
                check({v.name, " stall len"}, 64'(stall_cycles), 64'(v.stall_n));
                check({v.name, " stall stable"}, 64'(stall_bad), 64'd0);
            end
            if (v.mid) check({v.name, " elapsed same"}, elapsed, 64'(base_cyc));
`ifdef VERIFY_RAM_FIRST_ERR_EN
            check({v.name, " first_err"}, first_err_addr, v.exp_fe);
`endif
            if (i == 0) base_cyc = cyc;
            cor_blk = 0; resp_blk = 0; nolast_blk = 0; stall_left = 0;
            repeat (4) @(negedge clk);
        end

        // reset mid-pass with AR #4 stalled, then drain stray beats and rerun
        clear_slave();
        stall_idx = 4;
        stall_left = 30;
        stall_addr = BASE + 64'd768;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 200 && r_beats < 5; i++) @(negedge clk);
        check("mid-rst beats seen", 64'(r_beats >= 5), 64'd1);
        check("mid-rst arvalid before", 64'(arvalid), 64'd1);
        ram_reset = 1'b1;
        @(posedge clk);
        #1 ram_reset = 1'b0;
        stall_left = 0;
        @(negedge clk);
        check("mid-rst idle", 64'(idle), 64'd1);
        check("mid-rst arvalid", 64'(arvalid), 64'd0);
        check("mid-rst pass", 64'(pass), 64'd0);
        check("mid-rst err", 64'(error_count), 64'd0);
        check("mid-rst elapsed", elapsed, 64'd0);
        for (int i = 0; i < 200 && (burst_q.size() > 0 || r_valid); i++) @(negedge clk);
        check("drain done", 64'(burst_q.size()), 64'd0);
        check("drain err", 64'(error_count), 64'd0);
        check("drain elapsed", elapsed, 64'd0);
        check("drain idle", 64'(idle), 64'd1);
        clear_slave();
        run_pass(1'b0, cyc, to);
        check("rerun timeout", 64'(to), 64'd0);
        check("rerun pass", 64'(pass), 64'd1);
        check("rerun err", 64'(error_count), 64'd0);
        check("rerun ar count", 64'(ar_seen), 64'(NBLK));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
